// File: rtl/poly_sequencer.sv
// poly_sequencer: load/compute FSM for the A*X^2+B*X+C ALU datapath (POLY_SEQ_HORNER_EN selects the 4-cycle Horner schedule)
module poly_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic       ld_x,
  output logic       ld_alu_out,
  output logic       ld_r,
  output logic [1:0] alu_select_1,
  output logic [1:0] alu_select_2,
  output logic       alu_op,
  output logic       load_ready,
  output logic       busy,
  output logic       done
);
  typedef enum logic [3:0] {
    S_LOAD_A, S_LOAD_A_WAIT, S_LOAD_B, S_LOAD_B_WAIT,
    S_LOAD_C, S_LOAD_C_WAIT, S_LOAD_X, S_LOAD_X_WAIT,
    S_CYC0, S_CYC1, S_CYC2, S_CYC3, S_CYC4, S_DONE
  } state_t;
  state_t state, nxt;
  // state register, synchronous active-low reset
  always_ff @(posedge clk) state <= !resetn ? S_LOAD_A : nxt;
  // next state and Moore output decode
  always_comb begin
    nxt = S_LOAD_A;
    ld_a = 1'b0;
    ld_b = 1'b0;
    ld_c = 1'b0;
    ld_x = 1'b0;
    ld_alu_out = 1'b0;
    ld_r = 1'b0;
    alu_select_1 = 2'd0;
    alu_select_2 = 2'd0;
    alu_op = 1'b0;
    load_ready = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD_A: begin
        load_ready = 1'b1;
        ld_a = 1'b1;
        nxt = go ? S_LOAD_A_WAIT : S_LOAD_A;
      end
      S_LOAD_A_WAIT: begin
        load_ready = 1'b1;
        nxt = go ? S_LOAD_A_WAIT : S_LOAD_B;
      end
      S_LOAD_B: begin
        load_ready = 1'b1;
        ld_b = 1'b1;
        nxt = go ? S_LOAD_B_WAIT : S_LOAD_B;
      end
      S_LOAD_B_WAIT: begin
        load_ready = 1'b1;
        nxt = go ? S_LOAD_B_WAIT : S_LOAD_C;
      end
      S_LOAD_C: begin
        load_ready = 1'b1;
        ld_c = 1'b1;
        nxt = go ? S_LOAD_C_WAIT : S_LOAD_C;
      end
      S_LOAD_C_WAIT: begin
        load_ready = 1'b1;
        nxt = go ? S_LOAD_C_WAIT : S_LOAD_X;
      end
      S_LOAD_X: begin
        load_ready = 1'b1;
        ld_x = 1'b1;
        nxt = go ? S_LOAD_X_WAIT : S_LOAD_X;
      end
      S_LOAD_X_WAIT: begin
        load_ready = 1'b1;
        nxt = go ? S_LOAD_X_WAIT : S_CYC0;
      end
`ifdef POLY_SEQ_HORNER_EN
      S_CYC0: begin
        busy = 1'b1;
        alu_select_2 = 2'd3;
        alu_op = 1'b1;
        ld_a = 1'b1;
        ld_alu_out = 1'b1;
        nxt = S_CYC1;
      end
      S_CYC1: begin
        busy = 1'b1;
        alu_select_2 = 2'd1;
        ld_a = 1'b1;
        ld_alu_out = 1'b1;
        nxt = S_CYC2;
      end
      S_CYC2: begin
        busy = 1'b1;
        alu_select_2 = 2'd3;
        alu_op = 1'b1;
        ld_a = 1'b1;
        ld_alu_out = 1'b1;
        nxt = S_CYC3;
      end
      S_CYC3: begin
        busy = 1'b1;
        alu_select_2 = 2'd2;
        ld_r = 1'b1;
        nxt = S_DONE;
      end
`else
      S_CYC0, S_CYC1: begin
        busy = 1'b1;
        alu_select_2 = 2'd3;
        alu_op = 1'b1;
        ld_a = 1'b1;
        ld_alu_out = 1'b1;
        nxt = state == S_CYC0 ? S_CYC1 : S_CYC2;
      end
      S_CYC2: begin
        busy = 1'b1;
        alu_select_1 = 2'd1;
        alu_select_2 = 2'd3;
        alu_op = 1'b1;
        ld_b = 1'b1;
        ld_alu_out = 1'b1;
        nxt = S_CYC3;
      end
      S_CYC3: begin
        busy = 1'b1;
        alu_select_2 = 2'd1;
        ld_a = 1'b1;
        ld_alu_out = 1'b1;
        nxt = S_CYC4;
      end
      S_CYC4: begin
        busy = 1'b1;
        alu_select_2 = 2'd2;
        ld_r = 1'b1;
        nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        nxt = S_LOAD_A;
      end
      default: nxt = S_LOAD_A;
    endcase
  end
endmodule

// File: tb/tb_poly_sequencer.sv
// tb_poly_sequencer: drives the sequencer against a behavioural datapath and checks results against the polynomial formula
module tb_poly_sequencer;
`ifdef POLY_SEQ_HORNER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 5;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic [7:0] din = 8'd0;
  logic ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_op, load_ready, busy, done;
  logic [1:0] alu_select_1, alu_select_2;
  logic [7:0] a, b, c, x, r, s1, s2, alu;
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  always #5 clk = ~clk;
  poly_sequencer dut (
    .clk(clk), .resetn(resetn), .go(go),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x),
    .ld_alu_out(ld_alu_out), .ld_r(ld_r),
    .alu_select_1(alu_select_1), .alu_select_2(alu_select_2),
    .alu_op(alu_op), .load_ready(load_ready), .busy(busy), .done(done)
  );
  function automatic logic [7:0] pick(input logic [1:0] s);
    return s == 2'd0 ? a : s == 2'd1 ? b : s == 2'd2 ? c : x;
  endfunction
  always_comb begin
    s1 = pick(alu_select_1);
    s2 = pick(alu_select_2);
    alu = alu_op ? 8'(s1 * s2) : 8'(s1 + s2);
  end
  always @(posedge clk) begin
    if (!resetn) begin
      a <= 8'd0;
      b <= 8'd0;
      c <= 8'd0;
      x <= 8'd0;
      r <= 8'd0;
    end else begin
      if (ld_a) a <= ld_alu_out ? alu : din;
      if (ld_b) b <= ld_alu_out ? alu : din;
      if (ld_c) c <= ld_alu_out ? alu : din;
      if (ld_x) x <= ld_alu_out ? alu : din;
      if (ld_r) r <= alu;
    end
  end
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load_op(input logic [7:0] v, input int idx);
    check("load_en", {ld_a, ld_b, ld_c, ld_x}, 4'b1000 >> idx);
    check("load_ready", load_ready, 1);
    din = v;
    go = 1'b1;
    step(1);
    go = 1'b0;
    din = 8'($urandom);
    step(1);
  endtask
  task automatic finish_run(input logic [7:0] pa, pb, pc, px);
    int n = 0;
    int bsy = 0;
    int dc0 = done_cnt;
    int exp = (int'(pa) * int'(px) * int'(px) + int'(pb) * int'(px) + int'(pc)) % 256;
    while (!done && n < 20) begin
      if (busy) bsy++;
      step(1);
      n++;
    end
    check("latency", n, LAT);
    check("busy_cycles", bsy, LAT);
    check("result", r, exp);
    step(1);
    check("done_pulses", done_cnt - dc0, 1);
    check("back_to_load_a", {load_ready, ld_a, done, busy}, 4'b1100);
    check("result_hold", r, exp);
  endtask
  task automatic run(input logic [7:0] pa, pb, pc, px);
    load_op(pa, 0);
    load_op(pb, 1);
    load_op(pc, 2);
    load_op(px, 3);
    finish_run(pa, pb, pc, px);
  endtask
  initial begin
    int dc;
    step(2);
    check("rst_ready_lda", {load_ready, ld_a}, 2'b11);
    check("rst_others", {ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_select_1, alu_select_2, alu_op, busy, done}, 0);
    resetn = 1'b1;
    step(1);
    check("idle_stays", {load_ready, ld_a}, 2'b11);
    run(8'd2, 8'd3, 8'd4, 8'd5);
    run(8'd16, 8'd0, 8'd1, 8'd16);
    run(8'd255, 8'd255, 8'd255, 8'd255);
    din = 8'd77;
    go = 1'b1;
    step(1);
    din = 8'd9;
    step(9);
    check("held_a_value", a, 77);
    check("held_parked", {load_ready, ld_a, ld_b}, 3'b100);
    go = 1'b0;
    step(1);
    check("held_release", {load_ready, ld_b}, 2'b11);
    load_op(8'd1, 1);
    load_op(8'd2, 2);
    load_op(8'd3, 3);
    finish_run(8'd77, 8'd1, 8'd2, 8'd3);
    run(8'd7, 8'd1, 8'd1, 8'd1);
    dc = done_cnt;
    load_op(8'd5, 0);
    load_op(8'd6, 1);
    load_op(8'd7, 2);
    load_op(8'd8, 3);
    step(2);
    check("mid_busy", busy, 1);
    resetn = 1'b0;
    step(1);
    check("mid_rst_state", {load_ready, ld_a, busy}, 3'b110);
    check("mid_rst_result", r, 0);
    resetn = 1'b1;
    step(8);
    check("mid_rst_no_done", done_cnt - dc, 0);
    check("mid_rst_idle", {load_ready, ld_a}, 2'b11);
    for (int k = 0; k < 6; k++)
      run(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/poly_sequencer.md
# poly_sequencer

Control FSM for the 8-bit four-register ALU datapath in `animationData`, which holds registers a, b, c and x and produces `data_result`. It loads A, B, C and X from `data_in` through a press/release `go` handshake. It then steps the ALU to evaluate A·X² + B·X + C modulo 256 and latches the result into the datapath result register. It drives every datapath control line and exposes status to the top-level.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- go  in  1  operand-accept strobe (level, debounced upstream)
- ld_a, ld_b, ld_c, ld_x  out  1 each  datapath register load enables
- ld_alu_out  out  1  1 = registers load ALU output; 0 = registers load data_in
- ld_r  out  1  result-register load enable
- alu_select_1, alu_select_2  out  2 each  ALU operand mux: 0=a, 1=b, 2=c, 3=x
- alu_op  out  1  0 = add, 1 = multiply
- load_ready  out  1  high in any S_LOAD_* state
- busy  out  1  high in any S_CYC* state
- done  out  1  one-cycle pulse; data_result is valid in this cycle

## Operation
- Moore FSM. All outputs decode combinationally from the state register only. Any output not listed for a state is 0.
- Operand load:
  - S_LOAD_A: ld_a=1. Go to S_LOAD_A_WAIT when go=1. A captures data_in on the edge where go is sampled 1.
  - S_LOAD_A_WAIT: all loads 0. Go to S_LOAD_B when go=0.
  - B, C and X follow the same pair pattern. S_LOAD_X_WAIT exits to S_CYC0 when go=0.
- Compute, default build, 5 cycles:
  - S_CYC0: a←a·x. Sel 0,3; op=1; ld_a; ld_alu_out.
  - S_CYC1: a←a·x. Same controls as S_CYC0.
  - S_CYC2: b←b·x. Sel 1,3; op=1; ld_b; ld_alu_out.
  - S_CYC3: a←a+b. Sel 0,1; op=0; ld_a; ld_alu_out.
  - S_CYC4: r←a+c. Sel 0,2; op=0; ld_r.
- S_DONE: done=1. Unconditionally go to S_LOAD_A next cycle.
- Arithmetic: 8-bit, every intermediate truncated mod 256. The result equals (A·X²+B·X+C) mod 256.
- go is ignored in S_CYC* and S_DONE. If go is still high on re-entry to S_LOAD_A, the FSM accepts immediately. A new A therefore needs go low, then high.
- Undefined state encodings: go to S_LOAD_A next cycle.

## Timing
- Reset: state=S_LOAD_A. load_ready=1 and ld_a=1. All other outputs 0.
- Reset mid-compute: the FSM returns to S_LOAD_A on the next edge and no done pulse is issued. Datapath registers reset through the same resetn.
- Latency from the edge leaving S_LOAD_X_WAIT to the done pulse: 5 cycles in the default build, 4 with the macro.
- data_result updates on the edge leaving the last S_CYC state. It holds until the next ld_r or reset.
- Minimum operand load: 2 cycles per operand (accept, then release).

## Configuration
- POLY_SEQ_HORNER_EN defined: Horner schedule, 4 compute cycles, register b unmodified.
  - S_CYC0: a←a·x (sel 0,3; op 1).
  - S_CYC1: a←a+b (sel 0,1; op 0).
  - S_CYC2: a←a·x (sel 0,3; op 1).
  - S_CYC3: r←a+c (sel 0,2; op 0; ld_r).
  - Then S_DONE.
- Undefined: the 5-cycle direct schedule above.
- The result is bit-identical in both builds.

## Test plan
- Basic: load A=2, B=3, C=4, X=5. Expect data_result=69 (0x45) and one done pulse, 5 cycles after X release (4 with the macro).
- Overflow: A=16, B=0, C=1, X=16. Expect data_result=1. Then A=255, B=255, C=255, X=255. Expect data_result=0xFF.
- Held go: hold go high for 10 cycles during A load. Expect a single A capture and the FSM parked in S_LOAD_A_WAIT. On release, load_ready stays 1 and ld_b=1.
- Reset mid-compute: assert resetn=0 in S_CYC2. Next cycle expect state S_LOAD_A, done never pulses, and data_result=0.
- Back-to-back: run two full sequences with go toggled between them. Expect two done pulses, each with the correct result, and busy high for exactly 5 (or 4) cycles each.
